// File: rtl/booth_ctrl.sv
// Sequencing controller for a radix-2 Booth multiplier: drives the A/Q/M register
// strobes and adder/subtractor select from the {Q[0], Q[-1]} status bits.
module booth_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             ld_a,
  output logic             sft_a,
  output logic             sft_q,
  output logic             clr_ff,
  output logic             addsub,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SCAN   = 3'd2,
    S_ARITH  = 3'd3,
    S_SHIFT  = 3'd4,
    S_FINISH = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic ld_m_q, ld_m_d;
  logic ld_q_q, ld_q_d;
  logic clr_a_q, clr_a_d;
  logic ld_a_q, ld_a_d;
  logic sft_a_q, sft_a_d;
  logic sft_q_q, sft_q_d;
  logic clr_ff_q, clr_ff_d;
  logic addsub_q, addsub_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  // Next-state, op latch and iteration count; strobes are decoded from the
  // next state so the registered outputs line up with the state they belong to.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    count_d  = count_q;
    ld_m_d   = 1'b0;
    ld_q_d   = 1'b0;
    clr_a_d  = 1'b0;
    ld_a_d   = 1'b0;
    sft_a_d  = 1'b0;
    sft_q_d  = 1'b0;
    clr_ff_d = 1'b0;
    addsub_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        count_d = CNT_W'(WIDTH);
        state_d = S_SCAN;
      end
      S_SCAN: begin
        case ({q0, qm1})
          2'b01: begin
            op_d    = 1'b1;
            state_d = S_ARITH;
          end
          2'b10: begin
            op_d    = 1'b0;
            state_d = S_ARITH;
          end
          default: state_d = S_SHIFT;
        endcase
      end
      S_ARITH: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        count_d = count_q - CNT_W'(1);
        state_d = (count_q == CNT_W'(1)) ? S_FINISH : S_SCAN;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_INIT: begin
        ld_m_d   = 1'b1;
        ld_q_d   = 1'b1;
        clr_a_d  = 1'b1;
        clr_ff_d = 1'b1;
        busy_d   = 1'b1;
      end
      S_SCAN: begin
        busy_d = 1'b1;
      end
      S_ARITH: begin
        ld_a_d   = 1'b1;
        addsub_d = op_d;
        busy_d   = 1'b1;
      end
      S_SHIFT: begin
        sft_a_d = 1'b1;
        sft_q_d = 1'b1;
        busy_d  = 1'b1;
      end
      S_FINISH: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // clr wins over everything and leaves op defaulted to add.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b1;
      count_q  <= '0;
      ld_m_q   <= 1'b0;
      ld_q_q   <= 1'b0;
      clr_a_q  <= 1'b0;
      ld_a_q   <= 1'b0;
      sft_a_q  <= 1'b0;
      sft_q_q  <= 1'b0;
      clr_ff_q <= 1'b0;
      addsub_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      count_q  <= count_d;
      ld_m_q   <= ld_m_d;
      ld_q_q   <= ld_q_d;
      clr_a_q  <= clr_a_d;
      ld_a_q   <= ld_a_d;
      sft_a_q  <= sft_a_d;
      sft_q_q  <= sft_q_d;
      clr_ff_q <= clr_ff_d;
      addsub_q <= addsub_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ld_m   = ld_m_q;
  assign ld_q   = ld_q_q;
  assign clr_a  = clr_a_q;
  assign ld_a   = ld_a_q;
  assign sft_a  = sft_a_q;
  assign sft_q  = sft_q_q;
  assign clr_ff = clr_ff_q;
  assign addsub = addsub_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign count  = count_q;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: behavioural A/Q/M/Q[-1] datapath driven by the strobes,
// results compared against signed arithmetic and the Booth recoding of Q.
module tb_booth_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic       q0, qm1;
  logic       ld_m, ld_q, clr_a, ld_a, sft_a, sft_q, clr_ff, addsub, busy, done;
  logic [3:0] count;

  logic [7:0] m_op = 8'h00;
  logic [7:0] q_op = 8'h00;
  logic [7:0] dp_a = 8'h00;
  logic [7:0] dp_q = 8'h00;
  logic [7:0] dp_m = 8'h00;
  logic       dp_qm1 = 1'b0;

  int checks = 0;
  int errors = 0;

  booth_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .q0(q0), .qm1(qm1),
    .ld_m(ld_m), .ld_q(ld_q), .clr_a(clr_a), .ld_a(ld_a), .sft_a(sft_a),
    .sft_q(sft_q), .clr_ff(clr_ff), .addsub(addsub), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;

  // Datapath reacting to the strobes at the edge that ends their cycle.
  always @(posedge clk) begin
    if (ld_m) dp_m <= m_op;
    if (ld_q) dp_q <= q_op;
    else if (sft_q) dp_q <= {dp_a[0], dp_q[7:1]};
    if (clr_ff) dp_qm1 <= 1'b0;
    else if (sft_q) dp_qm1 <= dp_q[0];
    if (clr_a) dp_a <= 8'h00;
    else if (ld_a) dp_a <= addsub ? dp_a + dp_m : dp_a - dp_m;
    else if (sft_a) dp_a <= {dp_a[7], dp_a[7:1]};
  end

  typedef struct {
    logic [7:0]  m;
    logic [7:0]  q;
    int          p1;
    int          p2;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] outs();
    return {ld_m, ld_q, clr_a, ld_a, sft_a, sft_q, clr_ff, addsub, busy, done};
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] q);
    int a, b;
    a = $signed(m);
    b = $signed(q);
    return 16'(a * b);
  endfunction

  function automatic int ref_arith(input logic [7:0] q);
    int   n = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (q[i] != prev) n++;
      prev = q[i];
    end
    return n;
  endfunction

  // One multiplication from a start pulse; start re-pulsed in cycles p1/p2.
  task automatic run_mult(input logic [7:0] m, input logic [7:0] q, input int p1,
                          input int p2, input logic [15:0] exp_prod, input int exp_lat,
                          input string tag);
    logic        exp_ops[$];
    logic        got_ops[$];
    logic        prev;
    logic [15:0] prod;
    int          cyc, inits, shifts, bad_cnt, bad_excl, bad_busy, bad_ops;
    bit          seen;
    prev = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (q[i] && !prev) exp_ops.push_back(1'b0);
      else if (!q[i] && prev) exp_ops.push_back(1'b1);
      prev = q[i];
    end
    @(negedge clk);
    m_op = m; q_op = q; start = 1'b1;
    cyc = 0; inits = 0; shifts = 0; bad_cnt = 0; bad_excl = 0; bad_busy = 0;
    seen = 1'b0; prod = 16'h0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1 || cyc == p2);
      if (ld_m) inits++;
      if (ld_a) got_ops.push_back(addsub);
      if (sft_a) begin
        if (count != 4'(8 - shifts)) bad_cnt++;
        shifts++;
      end
      if ((int'(ld_a) + int'(sft_a) + int'(clr_a)) > 1 || (ld_q && sft_q)) bad_excl++;
      if (busy == done) bad_busy++;
      if (done) begin
        seen = 1'b1;
        prod = {dp_a, dp_q};
        chk({tag, "_cnt_done"}, 32'(count), 32'd0);
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_latency_model"}, 32'(cyc), 32'(18 + exp_ops.size()));
    chk({tag, "_product"}, 32'(prod), 32'(exp_prod));
    chk({tag, "_inits"}, 32'(inits), 32'd1);
    chk({tag, "_shifts"}, 32'(shifts), 32'd8);
    chk({tag, "_nops"}, 32'(got_ops.size()), 32'(exp_ops.size()));
    bad_ops = 0;
    for (int i = 0; i < exp_ops.size() && i < got_ops.size(); i++)
      if (got_ops[i] !== exp_ops[i]) bad_ops++;
    chk({tag, "_op_order"}, 32'(bad_ops), 32'd0);
    chk({tag, "_count_seq"}, 32'(bad_cnt), 32'd0);
    chk({tag, "_exclusive"}, 32'(bad_excl), 32'd0);
    chk({tag, "_busy"}, 32'(bad_busy), 32'd0);
  endtask

  initial begin
    int          n;
    int          dones[$];
    int          inits[$];
    logic [7:0]  rm, rq;
    logic [15:0] p2nd;

    vecs[0] = '{m: 8'h05, q: 8'h00, p1: 0, p2: 0,  prod: 16'h0000, lat: 18};
    vecs[1] = '{m: 8'h03, q: 8'hFB, p1: 0, p2: 0,  prod: 16'hFFF1, lat: 21};
    vecs[2] = '{m: 8'h07, q: 8'h06, p1: 5, p2: 12, prod: 16'h002A, lat: 20};
    vecs[3] = '{m: 8'h7F, q: 8'h55, p1: 0, p2: 0,  prod: 16'h2A2B, lat: 26};
    vecs[4] = '{m: 8'hFF, q: 8'hFF, p1: 0, p2: 0,  prod: 16'h0001, lat: 19};

    // Reset priority over start.
    clr = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("rst_outs_a", 32'(outs()), 32'd0);
    @(negedge clk);
    chk("rst_outs_b", 32'(outs()), 32'd0);
    clr = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_outs", 32'(outs()), 32'd0);
      chk("post_rst_count", 32'(count), 32'd0);
    end

    foreach (vecs[i])
      run_mult(vecs[i].m, vecs[i].q, vecs[i].p1, vecs[i].p2, vecs[i].prod, vecs[i].lat,
               $sformatf("vec%0d", i));

    // clr during the first ARITH of 3 x -5.
    @(negedge clk);
    m_op = 8'h03; q_op = 8'hFB; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!ld_a && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("midclr_arith_found", 32'(ld_a), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    chk("midclr_outs", 32'(outs()), 32'd0);
    chk("midclr_count", 32'(count), 32'd0);
    clr = 1'b0;
    run_mult(8'h07, 8'h06, 0, 0, 16'h002A, 2 + 16 + ref_arith(8'h06), "after_clr");

    // start held high across two operations.
    @(negedge clk);
    m_op = 8'h07; q_op = 8'h06; start = 1'b1;
    p2nd = 16'h0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (ld_m) inits.push_back(c);
      if (done) begin
        dones.push_back(c);
        p2nd = {dp_a, dp_q};
      end
      if (dones.size() == 2) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b_ndone", 32'(dones.size()), 32'd2);
    chk("b2b_ninit", 32'(inits.size()), 32'd2);
    if (dones.size() == 2 && inits.size() == 2) begin
      chk("b2b_done1", 32'(dones[0]), 32'd20);
      chk("b2b_gap", 32'(inits[1] - dones[0]), 32'd2);
      chk("b2b_done2", 32'(dones[1]), 32'd41);
    end
    chk("b2b_product", 32'(p2nd), 32'h002A);

    // Randomized operands against the arithmetic model.
    for (int k = 0; k < 16; k++) begin
      rm = 8'($urandom_range(0, 255));
      if (rm == 8'h80) rm = 8'h7F;
      rq = 8'($urandom_range(0, 255));
      run_mult(rm, rq, int'($urandom_range(2, 17)), 0, ref_prod(rm, rq),
               18 + ref_arith(rq), $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_ctrl.md
# booth_ctrl

Sequencing controller for the radix-2 Booth multiplier. It drives the load/clear/shift strobes of the accumulator (A) and multiplier (Q) shift registers, the multiplicand (M) register load, the Q[-1] flip-flop clear, and the adder/subtractor select. It consumes only the two Booth status bits {Q[0], Q[-1]} from the datapath. It sits directly upstream of the shift registers and owns the iteration count and the start/done handshake.

## Interface
- WIDTH, 8: operand width; equals the number of Booth iterations.
- CNT_W, 4: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  reset; synchronous, active-high
- start  in  1  begin multiplication; level-sampled only in IDLE
- q0  in  1  Q register bit 0
- qm1  in  1  Q[-1] flip-flop
- ld_m  out  1  load M register from operand bus
- ld_q  out  1  load Q register from operand bus
- clr_a  out  1  clear A register
- ld_a  out  1  load A with adder/subtractor result
- sft_a  out  1  arithmetic right shift of A (s_in = A[WIDTH-1])
- sft_q  out  1  right shift of Q (s_in = A[0]); Q[-1] captures q0 on the same edge
- clr_ff  out  1  clear Q[-1]
- addsub  out  1  1 = A+M, 0 = A-M; meaningful only while ld_a=1
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- count  out  CNT_W  iterations remaining

## Operation
- Moore FSM. All strobes decode from the registered state plus the registered op bit, with no combinational path from q0/qm1 to outputs.
- States: IDLE, INIT, SCAN, ARITH, SHIFT, FINISH.
- IDLE:
  - All strobes are 0.
  - start=1 moves to INIT.
- INIT, one cycle:
  - Asserts ld_m, ld_q, clr_a, clr_ff.
  - count <= WIDTH.
  - Moves to SCAN.
- SCAN, one cycle, no strobes:
  - Samples {q0,qm1}.
  - 01 latches op=add and moves to ARITH.
  - 10 latches op=sub and moves to ARITH.
  - 00 or 11 moves to SHIFT.
- ARITH, one cycle:
  - ld_a=1, addsub=op.
  - Moves to SHIFT.
- SHIFT, one cycle:
  - sft_a=1, sft_q=1.
  - count <= count-1.
  - If count==1, moves to FINISH; otherwise moves to SCAN.
- FINISH, one cycle:
  - done=1.
  - Moves to IDLE. The product {A,Q} is stable from this cycle until the next INIT.
- busy=1 in INIT, SCAN, ARITH and SHIFT; busy=0 in IDLE and FINISH.
- count is unsigned and never wraps; it reaches 0 on the last SHIFT and holds 0 until the next INIT.
- Boundary behaviour:
  - start is ignored outside IDLE.
  - clr has priority over everything, including start. It forces IDLE, count=0 and op=add. All outputs are 0 in the following cycle, whatever the state was when clr arrived, including mid-ARITH.
  - start held high through FINISH: the FSM spends one cycle in IDLE, then enters INIT. There is no back-to-back skip of IDLE.
  - At most one of ld_a, sft_a, clr_a is high in any cycle. ld_q and sft_q are never high together.

## Timing
- Reset values: all outputs 0, count=0, state IDLE.
- Cycle numbering: start sampled high at edge E0. INIT is cycle 1, and the first SCAN is cycle 2.
- With A = number of ARITH visits, FINISH (done=1) falls in cycle 2+2·WIDTH+A.
- For WIDTH=8, latency is 18 cycles minimum and 26 maximum.
- Each strobe is high for exactly one cycle and acts at the rising edge ending that cycle.
- The datapath must present q0/qm1 reflecting the previous SHIFT by the next SCAN cycle. This holds automatically because SHIFT and SCAN are separate states.

## Test plan
All scenarios use a bench-side behavioural A/Q/M/Q[-1] datapath, WIDTH=8.
- **Reset priority:** clr=1 and start=1 for 2 cycles, then clr=0 with start=0 -> all outputs 0, count=0, busy stays 0.
- **No arithmetic:** M=8'h05, Q=8'h00 (q0/qm1 stay 00) -> ld_a never asserted, 8 sft_a pulses, done in cycle 18, product 16'h0000.
- **Signed operand:** M=3, Q=8'hFB (-5) -> ops in order sub, add, sub (A=3), done in cycle 21, product 16'hFFF1 (-15).
- **Start while busy:** start re-pulsed during cycles 5 and 12 of a 7×6 operation -> no extra INIT, count sequence undisturbed, product 16'h002A.
- **Reset mid-operation:** clr asserted during the first ARITH of 3×(-5) -> next cycle all outputs 0. Then start 7×6 -> product 16'h002A, done in cycle 2+16+A with A counted from the op sequence.
- **Back-to-back:** start held high continuously across two operations -> exactly one IDLE cycle between FINISH and the second INIT, and done pulses exactly once per operation.
